// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the round-robin control stage of the 4:1 channel mux.
// The optional MUX_RR_ARBITER_STATS_EN build uses CNT_W for its per-requester counters.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = $clog2(NUM_REQ);
  localparam int CNT_W   = 8;

  typedef enum logic {IDLE, GRANT} arb_state_t;
  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: returns the first set request found by
// searching ptr, ptr+1, ... modulo NUM_REQ.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  sel_t               ptr,
  output logic               found,
  output sel_t               idx
);

  logic [NUM_REQ-1:0] rot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign rot[gi] = req[sel_t'(ptr + sel_t'(gi))];
    end
  endgenerate

  // Scan from the far end so the entry closest to ptr is written last and wins.
  always_comb begin
    found = |req;
    idx   = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = sel_t'(ptr + sel_t'(i));
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select; holds the grant until out_valid & out_ready.
// Define MUX_RR_ARBITER_STATS_EN to add saturating per-requester handshake counters (gnt_cnt).
module mux_rr_arbiter
  import mux_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic               out_valid
`ifdef MUX_RR_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] gnt_cnt
`endif
);

  arb_state_t         state_reg, state_next;
  sel_t               sel_reg, sel_next;
  sel_t               ptr_reg, ptr_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic               handshake;
  sel_t               pick_ptr;
  sel_t               pick_idx;
  logic               pick_found;

  assign handshake = (state_reg == GRANT) && out_ready;

  // While granting, the search for the follow-on winner starts just past the channel being served.
  assign pick_ptr = (state_reg == GRANT) ? sel_t'(sel_reg + sel_t'(1)) : ptr_reg;

  rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      ptr_reg   <= '0;
      gnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = GRANT;
          sel_next   = pick_idx;
        end
      end
      GRANT: begin
        if (handshake) begin
          ptr_next = pick_ptr;
          if (pick_found) begin
            sel_next = pick_idx;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    gnt_next = (state_next == GRANT) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << sel_next) : '0;
  end

  always_comb begin
    sel       = sel_reg;
    gnt       = gnt_reg;
    out_valid = (state_reg == GRANT);
  end

`ifdef MUX_RR_ARBITER_STATS_EN
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (handshake && (sel_reg == sel_t'(gi)) && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign gnt_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed cycle table, then random traffic vs. a reference model.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       out_valid;
`ifdef MUX_RR_ARBITER_STATS_EN
  logic [31:0] gnt_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state: whether a grant is outstanding, who holds it, where the search starts.
  bit m_valid;
  int m_sel;
  int m_ptr;

  mux_rr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .out_valid (out_valid)
`ifdef MUX_RR_ARBITER_STATS_EN
    ,
    .gnt_cnt   (gnt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rdy;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       valid;
    logic       sel_chk;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int search(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge with the inputs in force at that edge.
  task automatic model_edge(input logic rn, input logic [3:0] r, input logic rdy);
    if (!rn) begin
      m_valid = 0; m_sel = 0; m_ptr = 0;
    end else if (!m_valid) begin
      if (r != 0) begin
        m_sel = search(m_ptr, r); m_valid = 1;
      end
    end else if (rdy) begin
      m_ptr = (m_sel + 1) % 4;
      if (r != 0) m_sel = search(m_ptr, r);
      else m_valid = 0;
    end
  endtask

  // Inputs change at negedge; outputs are sampled at the following negedge.
  task automatic step(input logic rn, input logic [3:0] r, input logic rdy);
    rst_n = rn; req = r; out_ready = rdy;
    @(posedge clk);
    model_edge(rn, r, rdy);
    @(negedge clk);
  endtask

  task automatic addv(input logic rn, input logic [3:0] r, input logic rdy,
                      input logic [1:0] s, input logic [3:0] g, input logic v, input logic sc);
    vq.push_back('{rst_n: rn, req: r, rdy: rdy, sel: s, gnt: g, valid: v, sel_chk: sc});
  endtask

  initial begin
    rst_n = 1'b0; req = 4'h0; out_ready = 1'b0;
    m_valid = 0; m_sel = 0; m_ptr = 0;

    // Reset held with all requests up
    addv(0, 4'hF, 0, 2'd0, 4'b0000, 0, 1);
    addv(0, 4'hF, 0, 2'd0, 4'b0000, 0, 1);
    addv(1, 4'hF, 0, 2'd0, 4'b0001, 1, 1);
    // Rotation with out_ready held
    addv(1, 4'hF, 1, 2'd1, 4'b0010, 1, 1);
    addv(1, 4'hF, 1, 2'd2, 4'b0100, 1, 1);
    addv(1, 4'hF, 1, 2'd3, 4'b1000, 1, 1);
    addv(1, 4'hF, 1, 2'd0, 4'b0001, 1, 1);
    addv(1, 4'hF, 1, 2'd1, 4'b0010, 1, 1);
    // Backpressure: grant on channel c stays locked while others rise
    addv(1, 4'b0100, 1, 2'd2, 4'b0100, 1, 1);
    for (int i = 0; i < 5; i++) addv(1, 4'b0100, 0, 2'd2, 4'b0100, 1, 1);
    addv(1, 4'b1010, 0, 2'd2, 4'b0100, 1, 1);
    addv(1, 4'b1010, 1, 2'd3, 4'b1000, 1, 1);
    // Sole requester b: wins every cycle, then drops to idle
    addv(1, 4'b0010, 1, 2'd1, 4'b0010, 1, 1);
    addv(1, 4'b0010, 1, 2'd1, 4'b0010, 1, 1);
    addv(1, 4'b0010, 1, 2'd1, 4'b0010, 1, 1);
    addv(1, 4'b0000, 1, 2'd0, 4'b0000, 0, 0);
    // Mid-grant reset while d is granted and stalled
    addv(1, 4'b1000, 0, 2'd3, 4'b1000, 1, 1);
    addv(1, 4'b1000, 0, 2'd3, 4'b1000, 1, 1);
    addv(0, 4'b1001, 0, 2'd0, 4'b0000, 0, 1);
    addv(1, 4'b1001, 0, 2'd0, 4'b0001, 1, 1);
    addv(1, 4'b1001, 1, 2'd3, 4'b1000, 1, 1);
    addv(1, 4'b0000, 1, 2'd0, 4'b0000, 0, 0);

    foreach (vq[i]) begin
      step(vq[i].rst_n, vq[i].req, vq[i].rdy);
      $display("vec %0d: rst_n=%0b req=%b rdy=%0b -> sel=%0d gnt=%b valid=%0b",
               i, vq[i].rst_n, vq[i].req, vq[i].rdy, sel, gnt, out_valid);
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vq[i].valid));
      chk($sformatf("vec%0d gnt", i), 32'(gnt), 32'(vq[i].gnt));
      if (vq[i].sel_chk) chk($sformatf("vec%0d sel", i), 32'(sel), 32'(vq[i].sel));
    end

    // Random traffic against the reference model, with occasional resets and stalls
    for (int n = 0; n < 500; n++) begin
      logic       rn;
      logic [3:0] r;
      logic       rdy;
      rn  = ($urandom_range(0, 63) != 0);
      r   = 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      step(rn, r, rdy);
      chk($sformatf("rnd%0d out_valid", n), 32'(out_valid), 32'(m_valid));
      chk($sformatf("rnd%0d gnt", n), 32'(gnt), m_valid ? (32'd1 << m_sel) : 32'd0);
      if (m_valid || !rn) chk($sformatf("rnd%0d sel", n), 32'(sel), 32'(m_sel));
    end
    $display("random phase: %0d cycles done", 500);

`ifdef MUX_RR_ARBITER_STATS_EN
    step(0, 4'h0, 0);
    chk("stats reset", gnt_cnt, 32'd0);
    for (int n = 0; n < 302; n++) step(1, 4'b0001, 1);
    chk("stats cnt_a saturated", 32'(gnt_cnt[7:0]), 32'd255);
    chk("stats others zero", 32'(gnt_cnt[31:8]), 32'd0);
    $display("stats: gnt_cnt=%h", gnt_cnt);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
